// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared FSM encoding, default widths and the saturating step helper
// used by the PWM duty ramp controller.
package pwm_ctrl_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, RAMP = 1'b1} state_t;
    localparam int unsigned PWM_PERIOD   = 10;
    localparam int unsigned DEF_DUTY_W   = 4;
    localparam int unsigned DEF_DUTY_MAX = PWM_PERIOD;
    function automatic int unsigned sat_step(input int unsigned v, input logic up, input int unsigned max);
        return up ? ((v >= max) ? max : v + 1) : ((v == 0) ? 0 : v - 1);
    endfunction
endpackage

// File: rtl/pwm_step_timer.sv
// pwm_step_timer: divides period_end pulses by RAMP_DIV and emits one step_tick per RAMP_DIV enabled pulses.
module pwm_step_timer #(
    parameter int unsigned RAMP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic step_tick
);
    localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [CW-1:0] r_cnt;
    logic          w_wrap;
    assign w_wrap    = (r_cnt == CW'(RAMP_DIV - 1));
    assign step_tick = enable && w_wrap;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl: arbitrates host and button duty requests, then ramps duty one step per RAMP_DIV PWM periods.
// Define PWM_RAMP_DONE_EN to add a done_pulse output that marks each completed ramp.
module pwm_duty_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned DUTY_W     = DEF_DUTY_W,
    parameter int unsigned DUTY_MAX   = DEF_DUTY_MAX,
    parameter int unsigned DUTY_RESET = 5,
    parameter int unsigned RAMP_DIV   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_end,
    input  logic              cmd_valid,
    input  logic [DUTY_W-1:0] cmd_target,
    output logic              cmd_ready,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    output logic [DUTY_W-1:0] duty,
    output logic              busy
`ifdef PWM_RAMP_DONE_EN
    ,
    output logic              done_pulse
`endif
);
    state_t            r_state;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] w_req;
    logic [DUTY_W-1:0] w_step;
    logic              w_hs;
    logic              w_tick;
    logic              w_last;
    // Host beats buttons; simultaneous inc+dec cancel out and leave the request at the current duty.
    always_comb begin
        w_hs   = cmd_valid && (r_state == IDLE);
        w_req  = w_hs ? ((cmd_target > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : cmd_target)
               : (inc_pulse && !dec_pulse) ? DUTY_W'(sat_step(32'(r_duty), 1'b1, DUTY_MAX))
               : (dec_pulse && !inc_pulse) ? DUTY_W'(sat_step(32'(r_duty), 1'b0, DUTY_MAX))
               : r_duty;
        w_step = DUTY_W'(sat_step(32'(r_duty), r_target > r_duty, DUTY_MAX));
        w_last = w_tick && (w_step == r_target);
    end
    pwm_step_timer #(.RAMP_DIV(RAMP_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (r_state == IDLE),
        .enable   (period_end && (r_state == RAMP)),
        .step_tick(w_tick)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state  <= IDLE;
            r_duty   <= DUTY_W'(DUTY_RESET);
            r_target <= DUTY_W'(DUTY_RESET);
        end else if (r_state == IDLE) begin
            r_target <= w_req;
            r_state  <= (w_req != r_duty) ? RAMP : IDLE;
        end else if (w_tick) begin
            r_duty  <= w_step;
            r_state <= w_last ? IDLE : RAMP;
        end
    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state == RAMP);
    assign duty      = r_duty;
`ifdef PWM_RAMP_DONE_EN
    logic r_done;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_done <= 1'b0;
        else
            r_done <= (r_state == RAMP) && w_last;
    assign done_pulse = r_done;
`endif
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb_pwm_duty_ramp_ctrl: scoreboard bench; each accepted request queues its expected duty steps,
// and a monitor pops and checks every duty change as it appears.
module tb_pwm_duty_ramp_ctrl;
    localparam int RAMP_DIV = 4;
    typedef struct {int duty; int busy;} exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       period_end = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_target = 4'd0;
    logic       inc_pulse = 1'b0;
    logic       dec_pulse = 1'b0;
    logic       cmd_ready;
    logic       busy;
    logic [3:0] duty;
    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         pc = 0;
    int         prev_duty = 5;
    int         pe_since = 0;
    int         n_wait = 0;
    logic       last_pe = 1'b0;
`ifdef PWM_RAMP_DONE_EN
    logic       done_pulse;
    logic       done_exp = 1'b0;
    int         n_done = 0;
`endif

    always #5 clk = ~clk;

    pwm_duty_ramp_ctrl #(.DUTY_W(4), .DUTY_MAX(10), .DUTY_RESET(5), .RAMP_DIV(RAMP_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .period_end(period_end),
        .cmd_valid (cmd_valid),
        .cmd_target(cmd_target),
        .cmd_ready (cmd_ready),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .duty      (duty),
        .busy      (busy)
`ifdef PWM_RAMP_DONE_EN
        ,
        .done_pulse(done_pulse)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] t, input logic i, input logic d);
        @(posedge clk); #1;
        cmd_valid = v; cmd_target = t; inc_pulse = i; dec_pulse = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
    endtask

    task automatic push_ramp(input int from, input int to);
        int d = from;
        while (d != to) begin
            d += (to > d) ? 1 : -1;
            sb.push_back('{duty: d, busy: (d == to) ? 0 : 1});
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    // PWM counter model: period_end marks the 9 -> 0 wrap, one pulse every 10 clocks.
    initial forever begin
        @(posedge clk); #1;
        pc = (pc == 9) ? 0 : pc + 1;
        period_end = (pc == 9);
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_duty = duty;
            pe_since = 0;
        end else begin
`ifdef PWM_RAMP_DONE_EN
            done_exp = 1'b0;
`endif
            if (int'(duty) != prev_duty) begin
                if (sb.size() == 0)
                    check("unexpected_step", duty, prev_duty);
                else begin
                    e = sb.pop_front();
                    check("step_duty", duty, e.duty);
                    check("step_busy", busy, e.busy);
                    check("step_on_pe", last_pe, 1);
                    check("step_spacing", pe_since, RAMP_DIV);
`ifdef PWM_RAMP_DONE_EN
                    done_exp = (e.busy == 0);
`endif
                end
                pe_since = 0;
            end
`ifdef PWM_RAMP_DONE_EN
            if (done_pulse || done_exp) check("done_pulse", done_pulse, done_exp);
            if (done_pulse) n_done++;
`endif
            if (!busy) pe_since = 0;
            else if (period_end) pe_since++;
            prev_duty = duty;
        end
        last_pe = period_end;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_duty", duty, 5);
        check("reset_busy", busy, 0);
        check("reset_ready", cmd_ready, 1);
        repeat (50) @(negedge clk);
        check("hold_duty", duty, 5);
        check("hold_busy", busy, 0);

        push_ramp(5, 9);
        drive(1'b1, 4'd9, 1'b0, 1'b0);
        check("accept_busy", busy, 1);
        check("accept_ready", cmd_ready, 0);
        wait_idle("to9");
        check("duty_9", duty, 9);

        push_ramp(9, 10);
        drive(1'b1, 4'd15, 1'b0, 1'b0);
        wait_idle("clamp");
        check("duty_clamp", duty, 10);

        push_ramp(10, 0);
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        wait_idle("to0");
        check("duty_0", duty, 0);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        check("dec_at0_busy", busy, 0);
        repeat (50) @(negedge clk);
        check("dec_at0_duty", duty, 0);

        push_ramp(0, 5);
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        wait_idle("to5");

        push_ramp(5, 3);
        drive(1'b1, 4'd3, 1'b1, 1'b0);
        check("host_wins_busy", busy, 1);
        repeat (15) @(posedge clk);
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        wait_idle("to3");
        check("duty_3", duty, 3);

        drive(1'b0, 4'd0, 1'b1, 1'b1);
        check("incdec_busy", busy, 0);
        push_ramp(3, 5);
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        wait_idle("back5");
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        check("same_busy", busy, 0);
        repeat (20) @(negedge clk);

        push_ramp(5, 6);
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        wait_idle("inc");
        check("duty_inc", duty, 6);

        push_ramp(6, 9);
        drive(1'b1, 4'd9, 1'b0, 1'b0);
        n_wait = 0;
        while (duty != 4'd7 && n_wait < 500) begin
            @(negedge clk);
            n_wait++;
        end
        check("reached_7", duty, 7);
        @(posedge clk); #3;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midramp_rst_duty", duty, 5);
        check("midramp_rst_busy", busy, 0);
        check("midramp_rst_ready", cmd_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("post_rst_duty", duty, 5);
        check("post_rst_busy", busy, 0);
`ifdef PWM_RAMP_DONE_EN
        check("done_count", n_done, 7);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
